// File: rtl/sd_card_cmd_phys_if.sv
// Card-logic side of the SD CMD-line responder PHY: command hand-off and
// response hand-back signals. The CMD pad itself stays a plain inout port.
interface sd_card_cmd_phys_if;
  logic        idle_in;
  logic        resp_valid;
  logic        resp_none;
  logic [39:0] response_in;
  logic [39:0] command;
  logic        cmd_strobe;
  logic        crc_error;
  logic        resp_ack;
  logic        resp_done;
  logic        busy;

  // Card command decoder / response generator.
  modport master (
    output idle_in, resp_valid, resp_none, response_in,
    input  command, cmd_strobe, crc_error, resp_ack, resp_done, busy
  );

  // The PHY.
  modport slave (
    input  idle_in, resp_valid, resp_none, response_in,
    output command, cmd_strobe, crc_error, resp_ack, resp_done, busy
  );
endinterface

// File: rtl/sd_card_cmd_phys.sv
// Card-side SD CMD-line PHY. Receives 48-bit host commands, validates framing
// and CRC7, hands them to card logic, then serialises the card's response
// after an NCR-cycle turnaround. Line drive is fully registered.
module sd_card_cmd_phys #(
  parameter int unsigned NCR        = 2,
  parameter int unsigned FRAME_SIZE = 48
) (
  input  logic              sd_clock,
  input  logic              reset,
  sd_card_cmd_phys_if.slave bus,
  inout  wire               cmd_pin
);

  localparam int unsigned PayloadW = FRAME_SIZE - 8;
  localparam int unsigned CntW     = $clog2(FRAME_SIZE);
  localparam int unsigned NcrW     = $clog2(NCR + 1);

  typedef enum logic [2:0] {
    StIdle,
    StReceive,
    StCheck,
    StWaitResp,
    StTurnaround,
    StSend
  } state_e;

  // CRC7, x^7 + x^3 + 1, zero seed, MSB first.
  function automatic logic [6:0] crc7(input logic [PayloadW-1:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = '0;
    for (int i = PayloadW - 1; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return crc;
  endfunction

  state_e                state_q, state_d;
  logic [FRAME_SIZE-1:0] rx_q, rx_d;
  logic [FRAME_SIZE-1:0] tx_q, tx_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [NcrW-1:0]       ncr_cnt_q, ncr_cnt_d;
  logic [PayloadW-1:0]   command_q, command_d;
  logic                  oe_q, oe_d;
  logic                  out_q, out_d;
  logic                  cmd_strobe_q, cmd_strobe_d;
  logic                  crc_error_q, crc_error_d;
  logic                  resp_ack_q, resp_ack_d;
  logic                  resp_done_q, resp_done_d;

  logic [PayloadW-1:0]   resp_fixed;
  logic [6:0]            resp_crc;
  logic [6:0]            rx_crc;
  logic                  rx_valid;

  // The two bits after the start bit of a response are always 00.
  assign resp_fixed = {2'b00, bus.response_in[PayloadW-3:0]};
  assign resp_crc   = crc7(resp_fixed);
  assign rx_crc     = crc7(rx_q[FRAME_SIZE-1:8]);
  assign rx_valid   = rx_q[FRAME_SIZE-2] && (rx_q[7:1] == rx_crc) && rx_q[0];

  assign cmd_pin        = oe_q ? out_q : 1'bz;
  assign bus.command    = command_q;
  assign bus.cmd_strobe = cmd_strobe_q;
  assign bus.crc_error  = crc_error_q;
  assign bus.resp_ack   = resp_ack_q;
  assign bus.resp_done  = resp_done_q;
  assign bus.busy       = (state_q != StIdle);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    bit_cnt_d    = bit_cnt_q;
    ncr_cnt_d    = ncr_cnt_q;
    command_d    = command_q;
    oe_d         = oe_q;
    out_d        = out_q;
    cmd_strobe_d = 1'b0;
    crc_error_d  = 1'b0;
    resp_ack_d   = 1'b0;
    resp_done_d  = 1'b0;

    if (bus.idle_in) begin
      state_d = StIdle;
      oe_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!cmd_pin) begin
            rx_d      = '0;
            bit_cnt_d = CntW'(FRAME_SIZE - 2);
            state_d   = StReceive;
          end
        end
        StReceive: begin
          rx_d = {rx_q[FRAME_SIZE-2:0], cmd_pin};
          if (bit_cnt_q == '0) begin
            state_d = StCheck;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
        StCheck: begin
          if (rx_valid) begin
            command_d    = rx_q[FRAME_SIZE-1:8];
            cmd_strobe_d = 1'b1;
            state_d      = StWaitResp;
          end else begin
            crc_error_d = 1'b1;
            state_d     = StIdle;
          end
        end
        StWaitResp: begin
          if (bus.resp_valid) begin
            tx_d       = {resp_fixed, resp_crc, 1'b1};
            resp_ack_d = 1'b1;
            ncr_cnt_d  = NcrW'(NCR);
            state_d    = StTurnaround;
          end else if (bus.resp_none) begin
            resp_ack_d = 1'b1;
            state_d    = StIdle;
          end
        end
        StTurnaround: begin
          // Start bit is loaded on the edge where the counter reaches zero,
          // so exactly NCR released cycles follow the acknowledge edge.
          ncr_cnt_d = ncr_cnt_q - 1'b1;
          if (ncr_cnt_q <= NcrW'(1)) begin
            oe_d      = 1'b1;
            out_d     = tx_q[FRAME_SIZE-1];
            tx_d      = tx_q << 1;
            bit_cnt_d = CntW'(FRAME_SIZE - 1);
            state_d   = StSend;
          end
        end
        StSend: begin
          if (bit_cnt_q != '0) begin
            out_d     = tx_q[FRAME_SIZE-1];
            tx_d      = tx_q << 1;
            bit_cnt_d = bit_cnt_q - 1'b1;
          end else begin
            // End bit has been on the line for one full cycle.
            oe_d        = 1'b0;
            resp_done_d = 1'b1;
            state_d     = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers; async reset releases the line at once.
  always_ff @(posedge sd_clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      rx_q         <= '0;
      tx_q         <= '0;
      bit_cnt_q    <= '0;
      ncr_cnt_q    <= '0;
      command_q    <= '0;
      oe_q         <= 1'b0;
      out_q        <= 1'b1;
      cmd_strobe_q <= 1'b0;
      crc_error_q  <= 1'b0;
      resp_ack_q   <= 1'b0;
      resp_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      bit_cnt_q    <= bit_cnt_d;
      ncr_cnt_q    <= ncr_cnt_d;
      command_q    <= command_d;
      oe_q         <= oe_d;
      out_q        <= out_d;
      cmd_strobe_q <= cmd_strobe_d;
      crc_error_q  <= crc_error_d;
      resp_ack_q   <= resp_ack_d;
      resp_done_q  <= resp_done_d;
    end
  end

endmodule

// File: tb/tb_sd_card_cmd_phys.sv
// Directed bench for sd_card_cmd_phys: a table of host frames with expected
// command/response outcomes, plus hand-written reset and abort sequences.
module tb_sd_card_cmd_phys;

  localparam int unsigned NCR = 2;

  logic clk      = 1'b0;
  logic reset    = 1'b0;
  logic host_oe  = 1'b0;
  logic host_bit = 1'b1;
  wire  cmd_line;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pullup (cmd_line);
  assign cmd_line = host_oe ? host_bit : 1'bz;

  sd_card_cmd_phys_if bus_if ();

  sd_card_cmd_phys #(
    .NCR       (NCR),
    .FRAME_SIZE(48)
  ) dut (
    .sd_clock(clk),
    .reset   (reset),
    .bus     (bus_if.slave),
    .cmd_pin (cmd_line)
  );

  typedef struct {
    logic [47:0] frame;
    logic        valid;
    logic        use_resp;
    logic        also_none;
    logic [39:0] response;
    logic [39:0] exp_cmd;
    logic [47:0] exp_tx;
  } vec_t;

  vec_t vecs [8];

  // Reference CRC7 by long division of {data, 7'b0} by 0x89.
  function automatic logic [6:0] crc7_model(input logic [39:0] d);
    logic [46:0] r;
    r = {d, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_frame(input logic [39:0] d);
    return {d, crc7_model(d), 1'b1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after release (edge E+48 next).
  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      host_oe  = 1'b1;
      host_bit = f[i];
      @(negedge clk);
    end
    host_oe  = 1'b0;
    host_bit = 1'b1;
  endtask

  // Called at the negedge where WAIT_RESP is current; response_in preset.
  task automatic run_response(input logic [47:0] exp_tx, input logic also_none,
                              input string tag);
    logic [47:0] cap;
    int          stray;
    bus_if.resp_valid = 1'b1;
    bus_if.resp_none  = also_none;
    @(negedge clk);
    check($sformatf("%s resp_ack", tag), bus_if.resp_ack, 1);
    check($sformatf("%s strobe width", tag), bus_if.cmd_strobe, 0);
    bus_if.resp_valid = 1'b0;
    bus_if.resp_none  = 1'b0;
    for (int i = 0; i < NCR; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("%s turnaround %0d released", tag, i), cmd_line, 1);
    end
    stray = 0;
    for (int i = 47; i >= 0; i--) begin
      @(negedge clk);
      cap[i] = cmd_line;
      if (bus_if.resp_done) stray++;
    end
    check($sformatf("%s tx frame", tag), cap, exp_tx);
    check($sformatf("%s tx leading bits", tag), cap[47:46], 2'b00);
    check($sformatf("%s early resp_done", tag), stray, 0);
    @(negedge clk);
    check($sformatf("%s resp_done", tag), bus_if.resp_done, 1);
    check($sformatf("%s idle after send", tag), bus_if.busy, 0);
    check($sformatf("%s line released", tag), cmd_line, 1);
    @(negedge clk);
    check($sformatf("%s resp_done width", tag), bus_if.resp_done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [39:0] keep_cmd;

    bus_if.idle_in     = 1'b0;
    bus_if.resp_valid  = 1'b0;
    bus_if.resp_none   = 1'b0;
    bus_if.response_in = '0;

    vecs[0] = '{48'h40_0000_0000_95, 1'b1, 1'b0, 1'b0, 40'h0, 40'h40_0000_0000, 48'h0};
    vecs[1] = '{48'h48_0000_01AA_87, 1'b1, 1'b1, 1'b0, 40'h00_0000_0000,
                40'h48_0000_01AA, 48'h00_0000_0000_01};
    vecs[2] = '{48'h48_0000_01AA_85, 1'b0, 1'b0, 1'b0, 40'h0, 40'h48_0000_01AA, 48'h0};
    vecs[3] = '{48'h40_0000_0000_95, 1'b1, 1'b1, 1'b0, 40'hFF_0000_0900,
                40'h40_0000_0000, mk_frame(40'h3F_0000_0900)};
    vecs[4] = '{48'h40_0000_0000_94, 1'b0, 1'b0, 1'b0, 40'h0, 40'h40_0000_0000, 48'h0};
    vecs[5] = '{48'h00_0000_0000_01, 1'b0, 1'b0, 1'b0, 40'h0, 40'h40_0000_0000, 48'h0};
    vecs[6] = '{mk_frame(40'h77_0000_0000), 1'b1, 1'b0, 1'b0, 40'h0,
                40'h77_0000_0000, 48'h0};
    vecs[7] = '{mk_frame(40'h51_0000_1000), 1'b1, 1'b1, 1'b1, 40'h00_1234_0900,
                40'h51_0000_1000, mk_frame(40'h00_1234_0900)};

    // Reset state, then idle line after release.
    repeat (3) @(negedge clk);
    check("reset busy", bus_if.busy, 0);
    check("reset command", bus_if.command, 40'h0);
    check("reset line", cmd_line, 1);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.busy || bus_if.cmd_strobe || bus_if.crc_error || bus_if.resp_ack ||
          bus_if.resp_done || cmd_line !== 1'b1) bad++;
    end
    check("idle after reset", bad, 0);

    // Table: frames are issued back-to-back whenever the previous is rejected.
    for (int v = 0; v < 8; v++) begin
      send_frame(vecs[v].frame);
      check($sformatf("v%0d strobe early", v), bus_if.cmd_strobe, 0);
      @(negedge clk);
      check($sformatf("v%0d cmd_strobe", v), bus_if.cmd_strobe, vecs[v].valid);
      check($sformatf("v%0d crc_error", v), bus_if.crc_error, !vecs[v].valid);
      check($sformatf("v%0d command", v), bus_if.command, vecs[v].exp_cmd);
      check($sformatf("v%0d busy", v), bus_if.busy, vecs[v].valid);
      if (vecs[v].valid) begin
        if (vecs[v].use_resp) begin
          bus_if.response_in = vecs[v].response;
          run_response(vecs[v].exp_tx, vecs[v].also_none, $sformatf("v%0d", v));
        end else begin
          bus_if.resp_none = 1'b1;
          @(negedge clk);
          check($sformatf("v%0d none ack", v), bus_if.resp_ack, 1);
          check($sformatf("v%0d none idle", v), bus_if.busy, 0);
          check($sformatf("v%0d none line", v), cmd_line, 1);
          bus_if.resp_none = 1'b0;
          @(negedge clk);
          check($sformatf("v%0d ack width", v), bus_if.resp_ack, 0);
        end
      end
    end

    // Async reset in the middle of a response.
    send_frame(48'h48_0000_01AA_87);
    @(negedge clk);
    check("rst seq strobe", bus_if.cmd_strobe, 1);
    bus_if.response_in = 40'h0;
    bus_if.resp_valid  = 1'b1;
    @(negedge clk);
    bus_if.resp_valid = 1'b0;
    repeat (NCR - 1) @(negedge clk);
    repeat (20) @(negedge clk);
    check("rst seq driving", cmd_line, 0);
    reset = 1'b0;
    #1;
    check("rst seq line released", cmd_line, 1);
    check("rst seq busy", bus_if.busy, 0);
    check("rst seq command", bus_if.command, 40'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus_if.resp_done || bus_if.cmd_strobe || bus_if.crc_error || cmd_line !== 1'b1)
        bad++;
    end
    check("rst seq no pulses", bad, 0);

    // idle_in abort during reception keeps the last command.
    keep_cmd = 40'h77_0000_0000;
    send_frame(mk_frame(keep_cmd));
    @(negedge clk);
    check("abort setup strobe", bus_if.cmd_strobe, 1);
    bus_if.resp_none = 1'b1;
    @(negedge clk);
    bus_if.resp_none = 1'b0;
    @(negedge clk);
    for (int i = 47; i >= 38; i--) begin
      host_oe  = 1'b1;
      host_bit = vecs[0].frame[i];
      @(negedge clk);
    end
    check("abort receiving", bus_if.busy, 1);
    bus_if.idle_in = 1'b1;
    host_oe        = 1'b0;
    host_bit       = 1'b1;
    @(negedge clk);
    bus_if.idle_in = 1'b0;
    check("abort idle", bus_if.busy, 0);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus_if.cmd_strobe || bus_if.crc_error || bus_if.busy) bad++;
    end
    check("abort no pulses", bad, 0);
    check("abort command kept", bus_if.command, keep_cmd);

    send_frame(48'h40_0000_0000_95);
    @(negedge clk);
    check("post abort strobe", bus_if.cmd_strobe, 1);
    check("post abort command", bus_if.command, 40'h40_0000_0000);
    bus_if.resp_none = 1'b1;
    @(negedge clk);
    check("post abort ack", bus_if.resp_ack, 1);
    bus_if.resp_none = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_card_cmd_phys.md
Name: sd_card_cmd_phys

Overview:
- Card-side (responder) physical layer for the SD CMD line. It is the counterpart of the host command PHY.
- Receives 48-bit host command frames serially from cmd_pin and validates start, transmission and end bits plus CRC7.
- Hands each valid command to card logic, then serializes the card's 48-bit response back onto cmd_pin after an NCR turnaround.
- Sits between the card pad and the card command decoder in card-model and loopback benches.

Parameters:
- NCR, 2, idle sd_clock cycles between accepting a response and driving its start bit (minimum 1).
- FRAME_SIZE, 48, command and response frame length in bits; fixed at 48 for this block.

Ports:
- sd_clock  input  1  single clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
- idle_in  input  1  synchronous abort: next state IDLE and the line is released.
- resp_valid  input  1  card logic presents a response on response_in.
- resp_none  input  1  card logic declares that the command has no response.
- response_in  input  40  response bits 47:8, MSB first; bits 39:38 are overridden to 2'b00.
- command  output  40  last valid command, frame bits 47:8; holds until the next valid command.
- cmd_strobe  output  1  one-cycle pulse: command updated.
- crc_error  output  1  one-cycle pulse: received frame rejected.
- resp_ack  output  1  one-cycle pulse: response or none accepted.
- resp_done  output  1  one-cycle pulse: response end bit transmitted.
- busy  output  1  high in every state except IDLE.
- cmd_pin  inout  1  SD CMD line; driven only while transmitting, otherwise Z (bench pulls up).

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; command=0.
  - cmd_strobe, crc_error, resp_ack, resp_done, busy all 0.
  - Line output-enable=0, so cmd_pin=Z within the same cycle.
  - A reset mid-frame aborts without any pulse.
- Line drive: output enable and output data are registered; cmd_pin changes only after a posedge. Reception samples cmd_pin at posedge.
- CRC7: polynomial x^7+x^3+1, register initialised to 0, computed over frame bits 47:8 MSB first.
- States:
  - IDLE: a sampled 0 on cmd_pin is start bit 47 -> RECEIVE, bit counter=46.
  - RECEIVE: shift in one bit per clock MSB first and decrement the counter. After bit 0 is sampled -> CHECK.
  - CHECK (1 cycle):
    - Valid frame: bit46=1, received CRC (bits 7:1) equals computed CRC, and bit0=1.
    - Valid -> command<=frame[47:8], cmd_strobe=1, next WAIT_RESP.
    - Invalid -> crc_error=1, command unchanged, next IDLE.
  - WAIT_RESP: no timeout.
    - resp_valid=1 -> latch response_in with [39:38] forced to 00, resp_ack=1, NCR counter=NCR, next TURNAROUND.
    - Else resp_none=1 -> resp_ack=1, next IDLE.
    - resp_valid and resp_none both 1: resp_valid wins.
    - cmd_pin activity is ignored in this state.
  - TURNAROUND: line stays Z; decrement the counter each cycle; at 0 -> SEND.
  - SEND:
    - Output-enable=1. Drive 40 latched bits MSB first, then 7 CRC bits, then end bit 1 (48 cycles total).
    - Output-enable drops at the posedge after the end bit cycle; resp_done pulses then; next IDLE.
    - Reception is disabled during TURNAROUND and SEND.
- Latency: start bit sampled at edge E -> cmd_strobe high in the cycle after edge E+48.
- Back-to-back frames: a start bit sampled in the first IDLE cycle after CHECK is accepted; the CHECK cycle itself does not sample.
- idle_in=1: highest priority after reset.
  - Next state IDLE; line released on the following edge.
  - No cmd_strobe or resp_done is produced for the aborted operation.
  - command keeps its last value.
- Pulses are exactly one cycle. busy is derived from the registered state.

Test Plan:
1. Reset released with cmd_pin pulled high for 20 cycles -> busy=0, no pulses, cmd_pin=Z.
2. Host sends 48'h40_0000_0000_95 (CMD0) -> cmd_strobe at edge E+49, command=40'h40_0000_0000, crc_error=0. Then resp_none -> resp_ack pulse, IDLE, line never driven.
3. Host sends 48'h48_0000_01AA_87 (CMD8) -> command=40'h48_0000_01AA. Then resp_valid with response_in=40'h00_0000_0000 -> after NCR=2 Z cycles, the line shows 48'h00_0000_0000_01, then resp_done.
4. CMD8 frame with CRC byte 0x85 -> crc_error pulse, no cmd_strobe, command unchanged, IDLE.
5. resp_valid with response_in=40'hFF_0000_0900 -> the transmitted frame begins with bits 00 (override), and its CRC matches the bench CRC7 model.
6. reset=0 asserted at bit 20 of SEND -> cmd_pin=Z immediately and no resp_done. idle_in asserted during RECEIVE -> IDLE with no pulse, and the next CMD0 is received correctly.
